// File: rtl/vga_tile_decoder_if.sv
// Video input, tile read port and frame status bundle for vga_tile_decoder.
// frame_crc exists only when TILE_CRC_EN is defined.
interface vga_tile_decoder_if;
    logic        hsync;
    logic        vsync;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic [6:0]  rd_addr;
    logic [2:0]  rd_code;
    logic        locked;
    logic        frame_valid;
    logic        decode_err;
    logic [15:0] frame_cnt;
`ifdef TILE_CRC_EN
    logic [7:0]  frame_crc;
`endif

    modport master (
`ifdef TILE_CRC_EN
        input  frame_crc,
`endif
        output hsync, vsync, red, green, blue, rd_addr,
        input  rd_code, locked, frame_valid, decode_err, frame_cnt
    );

    modport slave (
`ifdef TILE_CRC_EN
        output frame_crc,
`endif
        input  hsync, vsync, red, green, blue, rd_addr,
        output rd_code, locked, frame_valid, decode_err, frame_cnt
    );
endinterface

// File: rtl/vga_tile_decoder.sv
// Locks to a VGA stream, samples the centre of each tile of a 10x10 grid, double-buffers the codes.
// Optional TILE_CRC_EN adds a CRC-8 of each published frame on frame_crc.
//
// state   | meaning
// SEARCH  | waiting for a vsync falling edge to start measuring
// MEASURE | one frame of line/frame length checks before trusting the timing
// LOCKED  | timing trusted; tiles captured and frames published at vsync
module vga_tile_decoder #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_ACT   = 144,
    parameter int unsigned TILE_W  = 64,
    parameter int unsigned V_TOTAL = 521,
    parameter int unsigned V_ACT   = 31,
    parameter int unsigned TILE_H  = 48
) (
    input  logic              pixel_clk,
    input  logic              rst,
    vga_tile_decoder_if.slave vif
);

    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [9:0] HC_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_END  = 10'(H_SYNC);
    localparam logic [9:0] VC_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] CNT_MAX = 10'h3FF;
    localparam logic [6:0] N_TILES = 7'd100;

    state_t      state_q, state_d;
    logic        hs_q, vs_q;
    logic [9:0]  hc_q, hc_d, vc_q, vc_d, hc_cur;
    logic        meas_ok_q, meas_ok_d;
    logic [6:0]  samp_cnt_q, samp_cnt_d;
    logic        cap_err_q, cap_err_d;
    logic [2:0]  bank_q [0:1][0:99];
    logic [2:0]  bank_d [0:1][0:99];
    logic        sel_q, sel_d;
    logic        locked_q, locked_d;
    logic        frame_valid_q, frame_valid_d;
    logic        decode_err_q, decode_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]  rd_code_q, rd_code_d;
`ifdef TILE_CRC_EN
    logic [7:0]  crc_cap_q, crc_cap_d;
    logic [7:0]  frame_crc_q, frame_crc_d;
`endif

    logic        hs_fall, hs_rise, vs_fall;
    logic        line_bad, wid_bad, frame_bad;
    logic        col_hit, row_hit, tile_hit;
    logic [3:0]  col_idx, row_idx;
    logic [6:0]  tile_addr;
    logic [3:0]  px;

    function automatic logic [3:0] decode_px(input logic [2:0] r, input logic [2:0] g,
                                             input logic [1:0] b);
        if (g == 3'd7 && b == 2'd3 && r != 3'd0)
            return {1'b0, 3'd7 - r};
        return {1'b1, 3'd7};
    endfunction

`ifdef TILE_CRC_EN
    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [2:0] code);
        logic [7:0] c;
        c = crc ^ {5'b00000, code};
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction
`endif

    assign hs_fall = hs_q & ~vif.hsync;
    assign hs_rise = ~hs_q & vif.hsync;
    assign vs_fall = vs_q & ~vif.vsync;
    assign px      = decode_px(vif.red, vif.green, vif.blue);

    // hc_cur is the column of the pixel on the inputs this cycle; hc_q lags it by one.
    always_comb begin
        if (hs_fall)
            hc_cur = '0;
        else if (hc_q == CNT_MAX)
            hc_cur = hc_q;
        else
            hc_cur = hc_q + 10'd1;
    end

    always_comb begin
        col_hit = 1'b0;
        col_idx = '0;
        row_hit = 1'b0;
        row_idx = '0;
        for (int c = 0; c < 10; c++) begin
            if (hc_cur == 10'(H_ACT + TILE_W * c + TILE_W / 2)) begin
                col_hit = 1'b1;
                col_idx = 4'(c);
            end
        end
        for (int r = 0; r < 10; r++) begin
            if (vc_q == 10'(V_ACT + TILE_H * r + TILE_H / 2)) begin
                row_hit = 1'b1;
                row_idx = 4'(r);
            end
        end
        tile_hit  = col_hit & row_hit;
        tile_addr = 7'(7'(row_idx) * 7'd10) + {3'b000, col_idx};
    end

    always_comb begin
        state_d       = state_q;
        hc_d          = hc_cur;
        vc_d          = vc_q;
        meas_ok_d     = meas_ok_q;
        samp_cnt_d    = samp_cnt_q;
        cap_err_d     = cap_err_q;
        bank_d        = bank_q;
        sel_d         = sel_q;
        frame_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        decode_err_d  = decode_err_q;
`ifdef TILE_CRC_EN
        crc_cap_d     = crc_cap_q;
        frame_crc_d   = frame_crc_q;
`endif
        line_bad  = hs_fall && (hc_q != HC_LAST);
        wid_bad   = hs_rise && (hc_cur != HS_END);
        frame_bad = vs_fall && (vc_q != VC_LAST);

        if (vs_fall)
            vc_d = '0;
        else if (hs_fall && vc_q != CNT_MAX)
            vc_d = vc_q + 10'd1;

        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d   = MEASURE;
                    meas_ok_d = 1'b1;
                end
            end
            MEASURE: begin
                if (line_bad)
                    meas_ok_d = 1'b0;
                if (vs_fall) begin
                    if (meas_ok_q && !line_bad && !frame_bad) begin
                        state_d    = LOCKED;
                        samp_cnt_d = '0;
                        cap_err_d  = 1'b0;
`ifdef TILE_CRC_EN
                        crc_cap_d  = '0;
`endif
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (line_bad || wid_bad || frame_bad) begin
                    state_d    = SEARCH;
                    samp_cnt_d = '0;
                    cap_err_d  = 1'b0;
`ifdef TILE_CRC_EN
                    crc_cap_d  = '0;
`endif
                end else if (vs_fall) begin
                    // Only a fully sampled frame may replace the published bank.
                    if (samp_cnt_q == N_TILES) begin
                        sel_d         = ~sel_q;
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 16'd1;
                        decode_err_d  = cap_err_q;
`ifdef TILE_CRC_EN
                        frame_crc_d   = crc_cap_q;
`endif
                    end
                    samp_cnt_d = '0;
                    cap_err_d  = 1'b0;
`ifdef TILE_CRC_EN
                    crc_cap_d  = '0;
`endif
                end else if (tile_hit && samp_cnt_q != N_TILES) begin
                    bank_d[~sel_q][tile_addr] = px[2:0];
                    samp_cnt_d = samp_cnt_q + 7'd1;
                    cap_err_d  = cap_err_q | px[3];
`ifdef TILE_CRC_EN
                    crc_cap_d  = crc8_upd(crc_cap_q, px[2:0]);
`endif
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d = (state_d == LOCKED);
    end

    // Reading through sel_d lets a read in the swap cycle see the new bank.
    always_comb begin
        rd_code_d = 3'd7;
        if (vif.rd_addr < N_TILES)
            rd_code_d = bank_q[sel_d][vif.rd_addr];
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hc_q          <= '0;
            vc_q          <= '0;
            meas_ok_q     <= 1'b0;
            samp_cnt_q    <= '0;
            cap_err_q     <= 1'b0;
            sel_q         <= 1'b0;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            decode_err_q  <= 1'b0;
            frame_cnt_q   <= '0;
            rd_code_q     <= '0;
            for (int b = 0; b < 2; b++)
                for (int t = 0; t < 100; t++)
                    bank_q[b][t] <= '0;
`ifdef TILE_CRC_EN
            crc_cap_q     <= '0;
            frame_crc_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            hs_q          <= vif.hsync;
            vs_q          <= vif.vsync;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            meas_ok_q     <= meas_ok_d;
            samp_cnt_q    <= samp_cnt_d;
            cap_err_q     <= cap_err_d;
            sel_q         <= sel_d;
            locked_q      <= locked_d;
            frame_valid_q <= frame_valid_d;
            decode_err_q  <= decode_err_d;
            frame_cnt_q   <= frame_cnt_d;
            rd_code_q     <= rd_code_d;
            bank_q        <= bank_d;
`ifdef TILE_CRC_EN
            crc_cap_q     <= crc_cap_d;
            frame_crc_q   <= frame_crc_d;
`endif
        end
    end

    assign vif.rd_code     = rd_code_q;
    assign vif.locked      = locked_q;
    assign vif.frame_valid = frame_valid_q;
    assign vif.decode_err  = decode_err_q;
    assign vif.frame_cnt   = frame_cnt_q;
`ifdef TILE_CRC_EN
    assign vif.frame_crc   = frame_crc_q;
`endif

endmodule

// File: tb/tb_vga_tile_decoder.sv
// Directed bench for vga_tile_decoder on a scaled-down raster (56x26, 4x2 tiles) to keep frames short.
module tb_vga_tile_decoder;
    localparam int H_TOTAL = 56;
    localparam int H_SYNC  = 8;
    localparam int H_ACT   = 12;
    localparam int TILE_W  = 4;
    localparam int V_TOTAL = 26;
    localparam int V_ACT   = 4;
    localparam int TILE_H  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   fv_total = 0;
    int   exp_fv = 0;
    logic [6:0] rd_ptr = '0;
    logic [2:0] pat [100];
    logic [2:0] last_pat [100];
    logic [2:0] exp_pub [100];

    vga_tile_decoder_if vif ();

    vga_tile_decoder #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_ACT(H_ACT), .TILE_W(TILE_W),
        .V_TOTAL(V_TOTAL), .V_ACT(V_ACT), .TILE_H(TILE_H)
    ) dut (
        .pixel_clk (clk),
        .rst       (rst),
        .vif       (vif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && vif.frame_valid === 1'b1)
            fv_total++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bit-serial CRC-8 (poly 0x07, init 0) over the bench's published-bank model.
    function automatic logic [7:0] crc_of_pub();
        logic [7:0] c;
        logic [7:0] byte_v;
        logic       fb;
        c = 8'h00;
        for (int t = 0; t < 100; t++) begin
            byte_v = {5'b00000, exp_pub[t]};
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ byte_v[b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic set_bg();
        for (int i = 0; i < 100; i++) pat[i] = 3'd0;
    endtask

    task automatic drive_px(input int v, input int h);
        logic [2:0] code;
        code = 3'd7;
        vif.hsync = (h < H_SYNC) ? 1'b0 : 1'b1;
        vif.vsync = (v < 2) ? 1'b0 : 1'b1;
        if (h >= H_ACT && h < H_ACT + 10 * TILE_W && v >= V_ACT && v < V_ACT + 10 * TILE_H)
            code = pat[((v - V_ACT) / TILE_H) * 10 + (h - H_ACT) / TILE_W];
        if (code == 3'd7) begin
            vif.red = 3'd0; vif.green = 3'd0; vif.blue = 2'd0;
        end else begin
            vif.red = 3'd7 - code; vif.green = 3'd7; vif.blue = 2'd3;
        end
    endtask

    // One frame of raster; pub_now says whether the vsync edge opening it should publish.
    task automatic run_frame(input bit pub_now, input int short_v, input int rst_v);
        int         len;
        logic [2:0] exp_code;
        for (int v = 0; v < V_TOTAL; v++) begin
            len = (v == short_v) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                drive_px(v, h);
                vif.rd_addr = rd_ptr;
                if (v == rst_v && h == 0) begin
                    rst = 1'b1;
                    for (int i = 0; i < 100; i++) exp_pub[i] = 3'd0;
                end
                if (v == rst_v && h == 3) rst = 1'b0;
                @(posedge clk);
                #1;
                if (v == 0 && h == 0) begin
                    check("frame_valid_at_vsync", {31'd0, vif.frame_valid}, {31'd0, pub_now});
                    if (pub_now) begin
                        exp_pub = last_pat;
                        exp_fv++;
                    end
                end
                if (h == 0 && v == short_v)
                    check("locked_before_short_line", {31'd0, vif.locked}, 32'd1);
                if (h == 0 && short_v >= 0 && v == short_v + 1)
                    check("locked_after_short_line", {31'd0, vif.locked}, 32'd0);
                if (!(v == rst_v && h < 5)) begin
                    exp_code = (rd_ptr > 7'd99) ? 3'd7 : exp_pub[rd_ptr];
                    check($sformatf("rd_code[%0d]", rd_ptr), {29'd0, vif.rd_code}, {29'd0, exp_code});
                end
                rd_ptr++;
            end
        end
        last_pat = pat;
        check("frame_valid_count", fv_total, exp_fv);
    endtask

    task automatic end_chk(input logic lk, input int cnt, input logic derr);
        check("locked", {31'd0, vif.locked}, {31'd0, lk});
        check("frame_cnt", {16'd0, vif.frame_cnt}, cnt);
        check("decode_err", {31'd0, vif.decode_err}, {31'd0, derr});
    endtask

    initial begin
        vif.hsync = 1'b1; vif.vsync = 1'b1;
        vif.red = 3'd7; vif.green = 3'd7; vif.blue = 2'd3;
        vif.rd_addr = 7'd0;
        set_bg();
        last_pat = pat;
        for (int i = 0; i < 100; i++) exp_pub[i] = 3'd0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_locked", {31'd0, vif.locked}, 32'd0);
        check("reset_frame_valid", {31'd0, vif.frame_valid}, 32'd0);
        check("reset_decode_err", {31'd0, vif.decode_err}, 32'd0);
        check("reset_frame_cnt", {16'd0, vif.frame_cnt}, 32'd0);
        check("reset_rd_code", {29'd0, vif.rd_code}, 32'd0);
`ifdef TILE_CRC_EN
        check("reset_frame_crc", {24'd0, vif.frame_crc}, 32'd0);
`endif
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_locked", {31'd0, vif.locked}, 32'd0);

        // F1 measured, F2 first locked frame, F3 opens with first publish
        set_bg();
        run_frame(1'b0, -1, -1);  end_chk(1'b0, 0, 1'b0);
        run_frame(1'b0, -1, -1);  end_chk(1'b1, 0, 1'b0);
        set_bg(); pat[37] = 3'd2; pat[99] = 3'd6;
        run_frame(1'b1, -1, -1);  end_chk(1'b1, 1, 1'b0);
`ifdef TILE_CRC_EN
        check("frame_crc_all_zero", {24'd0, vif.frame_crc}, 32'd0);
`endif
        set_bg(); pat[0] = 3'd7;
        run_frame(1'b1, -1, -1);  end_chk(1'b1, 2, 1'b0);
        set_bg();
        run_frame(1'b1, -1, -1);  end_chk(1'b1, 3, 1'b1);

        // Short line in F6 drops lock; F6 is never published
        set_bg(); pat[37] = 3'd2; pat[99] = 3'd6;
        run_frame(1'b1, 10, -1);  end_chk(1'b0, 4, 1'b0);
        set_bg();
        run_frame(1'b0, -1, -1);  end_chk(1'b0, 4, 1'b0);
        run_frame(1'b0, -1, -1);  end_chk(1'b1, 4, 1'b0);
        set_bg(); pat[0] = 3'd1;
        run_frame(1'b1, -1, -1);  end_chk(1'b1, 5, 1'b0);
        set_bg();
        run_frame(1'b1, -1, -1);  end_chk(1'b1, 6, 1'b0);
`ifdef TILE_CRC_EN
        check("frame_crc_tile0_code1", {24'd0, vif.frame_crc}, {24'd0, crc_of_pub()});
`endif

        // Reset mid-frame: needs one MEASURE plus one LOCKED frame before publishing again
        set_bg(); pat[37] = 3'd2; pat[99] = 3'd6;
        run_frame(1'b1, -1, 12); end_chk(1'b0, 0, 1'b0);
        set_bg();
        run_frame(1'b0, -1, -1);  end_chk(1'b0, 0, 1'b0);
        run_frame(1'b0, -1, -1);  end_chk(1'b1, 0, 1'b0);
        run_frame(1'b1, -1, -1);  end_chk(1'b1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
